// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_pkg
// Purpose  : Shared definitions for the conditional-execution stage:
//            condition-field encodings and NZCV flag bit positions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cond_pkg;

  // Bit positions inside a 4-bit NZCV vector (registered Flags and ALUFlags).
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // The ALU drives its flag bus in the same order as the flag register.
  localparam int ALU_FLAG_N = FLAG_N;
  localparam int ALU_FLAG_Z = FLAG_Z;
  localparam int ALU_FLAG_C = FLAG_C;
  localparam int ALU_FLAG_V = FLAG_V;

  // Instruction condition field, Instr[31:28].
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module   : cond_check
// Purpose  : Purely combinational evaluation of a 4-bit condition field
//            against the registered NZCV flags.
// Ports    : cond_i   [3:0] in  condition field
//            flags_i  [3:0] in  registered NZCV flags
//            condex_o       out 1 = instruction executes
// Revision : 1.0 - initial release
// ============================================================================
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       condex_o
);

  logic n_w, z_w, c_w, v_w;

  assign n_w = flags_i[FLAG_N];
  assign z_w = flags_i[FLAG_Z];
  assign c_w = flags_i[FLAG_C];
  assign v_w = flags_i[FLAG_V];

  always_comb begin
    condex_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: condex_o = z_w;
      COND_NE: condex_o = ~z_w;
      COND_CS: condex_o = c_w;
      COND_CC: condex_o = ~c_w;
      COND_MI: condex_o = n_w;
      COND_PL: condex_o = ~n_w;
      COND_VS: condex_o = v_w;
      COND_VC: condex_o = ~v_w;
      COND_HI: condex_o = c_w & ~z_w;
      COND_LS: condex_o = ~c_w | z_w;
      COND_GE: condex_o = ~(n_w ^ v_w);
      COND_LT: condex_o = n_w ^ v_w;
      COND_GT: condex_o = ~z_w & ~(n_w ^ v_w);
      COND_LE: condex_o = z_w | (n_w ^ v_w);
      COND_AL: condex_o = 1'b1;
      // Reserved encoding squashes the instruction.
      default: condex_o = 1'b0;
    endcase
  end

endmodule : cond_check
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// Module   : cond_logic
// Purpose  : Conditional-execution stage. Holds the NZCV flag register as two
//            independently written halves (NZ, CV), evaluates the condition
//            field against the stored flags and gates the PC, register-file
//            and memory write enables.
// Ports    : clk           in   clock, rising-edge
//            reset         in   synchronous active-high reset
//            Cond     [3:0] in  condition field
//            ALUFlags [3:0] in  ALU flags this cycle (N,Z,C,V)
//            FlagW    [1:0] in  [1] writes NZ, [0] writes CV
//            PCS, RegW, MemW, NoWrite in  decoder write intents
//            PCSrc, RegWrite, MemWrite out gated enables
//            Flags    [3:0] out registered NZCV
// Revision : 1.0 - initial release
// ============================================================================
module cond_logic
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       condex_w;

  assign Flags = {nz_q, cv_q};

  // Condition is judged on the stored flags only, so ALUFlags never reach
  // an output combinationally.
  cond_check u_cond_check (
    .cond_i   (Cond),
    .flags_i  (Flags),
    .condex_o (condex_w)
  );

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (FlagW[1] && condex_w) nz_d = ALUFlags[FLAG_N:FLAG_Z];
    if (FlagW[0] && condex_w) cv_d = ALUFlags[FLAG_C:FLAG_V];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      nz_q <= nz_d;
      cv_q <= cv_d;
    end
  end

  // Enables are held low throughout reset regardless of decoder inputs.
  assign PCSrc    = ~reset & PCS  & condex_w;
  assign RegWrite = ~reset & RegW & condex_w & ~NoWrite;
  assign MemWrite = ~reset & MemW & condex_w;

endmodule : cond_logic
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_logic
// Purpose  : Self-checking bench for cond_logic: directed scenarios, an
//            exhaustive condition/flag sweep and randomized traffic against a
//            behavioural reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Cond = 4'b1110;
  logic [3:0] ALUFlags = 4'b0000;
  logic [1:0] FlagW = 2'b00;
  logic       PCS = 1'b0;
  logic       RegW = 1'b0;
  logic       MemW = 1'b0;
  logic       NoWrite = 1'b0;
  logic       PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags = 4'b0000;

  always #5 clk = ~clk;

  cond_logic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags)
  );

  // Reference: conditions come in pairs where the odd code is the negation
  // of the even one; 1111 is the reserved "never" code.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return base ^ c[0];
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction cycle: drive after the falling edge, check the
  // combinational enables, cross the rising edge, then check the flags.
  task automatic step(input logic rst, input logic [3:0] c, input logic [3:0] af,
                      input logic [1:0] fw, input logic pcs, input logic rw,
                      input logic mw, input logic nw);
    logic ex;
    @(negedge clk);
    reset = rst; Cond = c; ALUFlags = af; FlagW = fw;
    PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
    #1;
    ex = !rst && ref_cond(c, mflags);
    chk("PCSrc",    {3'b0, PCSrc},    {3'b0, pcs && ex});
    chk("RegWrite", {3'b0, RegWrite}, {3'b0, rw && ex && !nw});
    chk("MemWrite", {3'b0, MemWrite}, {3'b0, mw && ex});
    @(posedge clk);
    if (rst) mflags = 4'b0000;
    else if (ex) begin
      if (fw[1]) mflags[3:2] = af[3:2];
      if (fw[0]) mflags[1:0] = af[1:0];
    end
    #1;
    chk("Flags", Flags, mflags);
  endtask

  initial begin
    // Reset beats a full flag write; enables held low.
    step(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset_flags", Flags, 4'b0000);
    // EQ fails on cleared flags.
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("eq_after_reset", {3'b0, PCSrc}, 4'b0000);

    // Flag latency: Z set this cycle is not seen until the next.
    step(1'b0, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("latency_flags", Flags, 4'b0100);
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Partial writes.
    step(1'b0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b1110, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("partial_nz", Flags, 4'b0011);
    step(1'b0, 4'b1110, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("partial_cv", Flags, 4'b0001);

    // Failed condition squashes everything.
    step(1'b0, 4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0100, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("squash_flags", Flags, 4'b0000);

    // NoWrite suppresses only the register write.
    step(1'b0, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("nowrite_flags", Flags, 4'b1000);

    // Mid-stream reset: NE and GE pass, EQ and LT fail afterwards.
    step(1'b0, 4'b1110, 4'b0111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'b1011, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

    // Exhaustive sweep of every condition against every flag value.
    for (int f = 0; f < 16; f++) begin
      step(1'b0, 4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++)
        step(1'b0, 4'(c), 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    end

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cond_logic
`default_nettype wire

// File: doc/cond_logic.md
# cond_logic

Conditional-execution stage that consumes the ALU's `ALUFlags` and the decoder's raw write-intent signals. It holds the architectural NZCV flag register. It evaluates the instruction's 4-bit condition field against the stored flags. It gates the PC, register-file and memory write enables so that only instructions whose condition passes change architectural state.

## Interface
Parameters:
- none (flag width fixed at 4, condition width fixed at 4)

Ports:
- `clk`  in  1  processor clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `Cond`  in  4  instruction condition field, Instr[31:28]
- `ALUFlags`  in  4  flags from ALU this cycle; [3]=N, [2]=Z, [1]=C, [0]=V
- `FlagW`  in  2  decoder flag-write request; [1] writes N,Z; [0] writes C,V
- `PCS`  in  1  decoder: instruction writes PC (branch or Rd=R15)
- `RegW`  in  1  decoder: instruction writes register file
- `MemW`  in  1  decoder: instruction writes data memory
- `NoWrite`  in  1  decoder: suppress register write (CMP/CMN/TST/TEQ)
- `PCSrc`  out  1  gated PC-write select
- `RegWrite`  out  1  gated register-file write enable
- `MemWrite`  out  1  gated memory write enable
- `Flags`  out  4  current registered NZCV, same bit order as `ALUFlags`

## Operation
- Flag register: two independent 2-bit registers, NZ = `Flags[3:2]` and CV = `Flags[1:0]`.
- CondEx is combinational from `Cond` and the registered `Flags` only, never from `ALUFlags`. An instruction tests the flags left by earlier instructions.
- Condition decode (N,Z,C,V = registered flags):
  - 0000 EQ: Z; 0001 NE: !Z
  - 0010 CS: C; 0011 CC: !C
  - 0100 MI: N; 0101 PL: !N
  - 0110 VS: V; 0111 VC: !V
  - 1000 HI: C & !Z; 1001 LS: !C | Z
  - 1010 GE: N == V; 1011 LT: N != V
  - 1100 GT: !Z & (N == V); 1101 LE: Z | (N != V)
  - 1110 AL: 1; 1111 (reserved): 0, meaning the instruction is squashed
- Output gating:
  - PCSrc = PCS & CondEx
  - RegWrite = RegW & CondEx & !NoWrite
  - MemWrite = MemW & CondEx
- Flag write:
  - NZ loads `ALUFlags[3:2]` when FlagW[1] & CondEx.
  - CV loads `ALUFlags[1:0]` when FlagW[0] & CondEx.
  - Otherwise each register holds its value.
- A failed condition blocks all state change: no flag write, no PC, register or memory write.
- Reset:
  - Both flag registers clear to 0000 on the first rising edge with `reset`=1. Reset has priority over any FlagW.
  - While `reset`=1, PCSrc, RegWrite and MemWrite are forced 0 regardless of inputs.

## Timing
- Gated enables (PCSrc, RegWrite, MemWrite) are combinational, zero-cycle latency from Cond/PCS/RegW/MemW/NoWrite and registered Flags. They are valid within the same cycle as the instruction.
- Flag update latency is 1 cycle: `ALUFlags` sampled at edge k are visible on `Flags` and used for CondEx from cycle k+1.
- Back-to-back flag-setting instructions: each edge overwrites only the halves enabled that cycle. Partial writes, e.g. FlagW=10 after 11, leave C,V from the older instruction.
- Reset asserted mid-stream: flags are 0000 after that edge. CondEx then evaluates with N=Z=C=V=0, so EQ fails, NE passes, GE passes, LT fails.
- No internal combinational path from `ALUFlags` to any output except through the flag register.

## Structure
- Shared package `cond_pkg`:
  - enum `cond_e` with the 16 condition encodings
  - localparams `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`
  - The same package supplies the ALU flag-index constants.
- Sub-module `cond_check`: purely combinational (Cond, Flags) → CondEx, instantiated once.
- `cond_logic` holds the two flag registers, reset handling and the output gating.

## Test plan
- Reset clears flags: drive FlagW=11, ALUFlags=1111, Cond=1110 with reset=1 for one edge → Flags=0000, PCSrc=RegWrite=MemWrite=0 during reset. Release reset → Cond=0000 (EQ) with PCS=1 gives PCSrc=0.
- Flag latency: cycle 0 Cond=1110, FlagW=11, ALUFlags=0100 (Z) → cycle 0 Cond=0000, PCS=1 still gives PCSrc=0. Cycle 1 Cond=0000, PCS=1 → PCSrc=1, Flags=0100.
- Partial write: load Flags=1111 via FlagW=11, then FlagW=10, ALUFlags=0000 → Flags=0011. Then FlagW=01, ALUFlags=0001 → Flags=0001.
- Failed condition squashes everything: Flags=0000, Cond=0000, RegW=MemW=PCS=1, FlagW=11, ALUFlags=0100 → RegWrite=MemWrite=PCSrc=0, Flags remains 0000 next cycle.
- NoWrite: Cond=1110, RegW=1, NoWrite=1, FlagW=11, ALUFlags=1000 → RegWrite=0, Flags=1000 next cycle.
- Exhaustive condition sweep: all 16 Cond × 16 Flags values against the decode list → CondEx matches for every combination, and Cond=1111 always gives 0.
